// File: rtl/fib_sequencer.sv
// +--------------------------------------------------------------------+
// | fib_sequencer: emits the fixed LOAD/STORE/COPY/ADD program that    |
// | drives the Fibonacci datapath for F(0)..F(n-1).  Rev 1.0           |
// +--------------------------------------------------------------------+
`default_nettype none

module fib_sequencer #(
  parameter int CNT_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_terms,
  input  logic              stall,
  output logic [2:0]        opcode,
  output logic [1:0]        op1,
  output logic [1:0]        op2,
  output logic [DATA_W-1:0] ld_value,
  output logic              busy,
  output logic              term_valid,
  output logic [CNT_W-1:0]  term_idx,
  output logic              done
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_ADD   = 3'b110;
  localparam logic [2:0] OP_COPY  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L0   = 3'd1,
    S_L1   = 3'd2,
    S_ST   = 3'd3,
    S_CA   = 3'd4,
    S_AD   = 3'd5,
    S_CB   = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [CNT_W-1:0] idx, idx_nxt;
  logic             hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rem   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      idx   <= idx_nxt;
    end
  end

  assign hold = stall && (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    idx_nxt    = idx;
    opcode     = OP_NOP;
    op1        = 2'd0;
    op2        = 2'd0;
    ld_value   = '0;
    term_valid = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          rem_nxt   = n_terms;
          idx_nxt   = '0;
          state_nxt = (n_terms != '0) ? S_L0 : S_DONE;
        end
      end
      S_L0: begin
        opcode    = OP_LOAD;
        state_nxt = S_L1;
      end
      S_L1: begin
        opcode    = OP_LOAD;
        op1       = 2'd1;
        ld_value  = DATA_W'(1);
        state_nxt = S_ST;
      end
      S_ST: begin
        opcode     = OP_STORE;
        term_valid = 1'b1;
        state_nxt  = S_CA;
      end
      S_CA: begin
        opcode    = OP_COPY;
        op1       = 2'd2;
        op2       = 2'd1;
        state_nxt = S_AD;
      end
      S_AD: begin
        opcode    = OP_ADD;
        op1       = 2'd1;
        state_nxt = S_CB;
      end
      S_CB: begin
        opcode    = OP_COPY;
        op2       = 2'd2;
        rem_nxt   = rem - CNT_W'(1);
        idx_nxt   = idx + CNT_W'(1);
        state_nxt = (rem == CNT_W'(1)) ? S_DONE : S_ST;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // A stalled instruction becomes a bubble and re-issues once stall drops.
    if (hold) begin
      state_nxt  = state;
      rem_nxt    = rem;
      idx_nxt    = idx;
      opcode     = OP_NOP;
      op1        = 2'd0;
      op2        = 2'd0;
      ld_value   = '0;
      term_valid = 1'b0;
    end
  end

  assign busy     = (state != S_IDLE);
  assign term_idx = term_valid ? idx : '0;

endmodule

`default_nettype wire

// File: doc/fib_sequencer.md
# fib_sequencer

Instruction sequencer for the Fibonacci datapath. On `start` it emits a fixed program on the 3-bit opcode / 2-bit operand bus that feeds the instruction decoder and the 4-entry register file. The program computes F(0)..F(n-1) and issues one STORE per term so the output stage can capture it. It also supplies the constant driven onto the datapath load-data input during LOAD instructions.

## Interface
Parameters:
- `CNT_W`, default 8: width of the term-count input and the internal counters.
- `DATA_W`, default 8: width of `ld_value`.

Ports:
- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a run. Sampled only in IDLE.
- `n_terms`, input, CNT_W: number of terms to produce. Latched when `start` is accepted.
- `stall`, input, 1: hold request from the downstream consumer.
- `opcode`, output, 3: instruction opcode. 000 NOP, 001 SET, 010 INC, 011 DEC, 100 LOAD, 101 STORE, 110 ADD, 111 COPY.
- `op1`, output, 2: destination / first source register.
- `op2`, output, 2: second source register.
- `ld_value`, output, DATA_W: constant for the datapath load mux. Meaningful only while `opcode` is LOAD; otherwise 0.
- `busy`, output, 1: high in every state except IDLE.
- `term_valid`, output, 1: high during an issued (non-stalled) STORE cycle.
- `term_idx`, output, CNT_W: index of the term being stored.
- `done`, output, 1: one-cycle pulse at the end of a run.

## Operation
- Register usage:
  - R0 holds F(k).
  - R1 holds F(k+1).
  - R2 is scratch.
  - R3 is unused; it is never addressed.
- The FSM is Moore. `opcode`/`op1`/`op2`/`ld_value` are decoded from the state register. The only exception is `stall`, which forces the output to NOP.
- States, the instruction issued in each, and the next state:
  - IDLE: NOP. On `start`=1, latch `n_terms` into `rem` and clear `idx`. Go to L0 if `n_terms`≠0, otherwise to DONE.
  - L0: LOAD op1=0, op2=0, `ld_value`=0. Next L1.
  - L1: LOAD op1=1, op2=0, `ld_value`=1. Next ST.
  - ST: STORE op1=0, op2=0. `term_valid`=1 and `term_idx`=`idx`. Next CA.
  - CA: COPY op1=2, op2=1 (R2←R1). Next AD.
  - AD: ADD op1=1, op2=0 (R1←R1+R0). Next CB.
  - CB: COPY op1=0, op2=2 (R0←R2). On leaving CB, `rem`←`rem`−1 and `idx`←`idx`+1. Next DONE if `rem`==1 (before the decrement), otherwise ST.
  - DONE: NOP. `done`=1. Next IDLE.
- Stall: in any state other than IDLE or DONE, `stall`=1 has these effects:
  - the outputs show NOP with op1=op2=0 and `ld_value`=0;
  - `term_valid`=0;
  - the state, `rem` and `idx` hold.
  - The instruction re-issues in the first cycle with `stall`=0.
  - `stall` is ignored in IDLE and DONE.
- `start` is ignored while `busy`. A changing `n_terms` mid-run has no effect.
- Width rules:
  - `rem` and `idx` are CNT_W bits. `n_terms`=2^CNT_W−1 is the maximum.
  - `idx` never wraps within a run.
  - Term value overflow is a datapath concern; the sequencer does not observe data.

## Timing
- Reset (`rst_n`=0, asynchronous, at any time including mid-run):
  - state becomes IDLE; `rem`=0; `idx`=0.
  - `opcode`=000, `op1`=`op2`=0, `ld_value`=0.
  - `busy`=0, `term_valid`=0, `term_idx`=0, `done`=0.
  - The aborted run leaves no pending pulse.
- Run latency:
  - `start` is sampled at edge E0.
  - L0 is issued in cycle 1 and L1 in cycle 2.
  - Term k's STORE is issued in cycle 3+4k.
  - DONE occurs in cycle 3+4n, so an unstalled run takes 4n+3 cycles.
  - Each stall cycle adds one cycle.
- n=0: DONE in cycle 1, with no LOAD or STORE issued.
- `busy` rises in cycle 1 and falls in the cycle after DONE. A new `start` is accepted in that IDLE cycle, giving back-to-back runs with one IDLE cycle between them.
- `done` and `term_valid` are never high in the same cycle.

## Test plan
- Reset, then `start`, `n_terms`=5, no stall:
  - opcode stream is 100,100, then (101,111,110,111)×5, then 000;
  - `term_idx` is 0..4 across the STORE cycles;
  - `done` occurs at cycle 23;
  - a datapath model stores 0,1,1,2,3.
- `n_terms`=0: `done` in cycle 1, `busy` high for exactly that one cycle, no LOAD or STORE issued.
- `n_terms`=3 with `stall` high for 2 cycles during AD of term 1: NOP for 2 cycles, then ADD op1=1, op2=0 re-issued; `done` at cycle 17 (15+2); stored values 0,1,1.
- `rst_n` pulsed low mid-run at term 2 (`n_terms`=6): all outputs go to reset values immediately. A subsequent `start` with `n_terms`=2 produces the full fresh sequence, `term_idx` 0,1, and `done` at cycle 11.
- `start` held high across a run with `n_terms`=1: run 1 ends with `done` at cycle 7, IDLE in cycle 8, and a new run starts with L0 in cycle 9. `start` pulses while busy are ignored.
- `n_terms`=255: 255 STOREs, `term_idx` 0..254 with no wrap, `done` at cycle 1023.
